control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - multicycle Moore control FSM driving datapath enables and selects
// Optional macro CONTROL_OVERFLOW_TRAP_EN: ADD/ADDI overflow diverts to TRAP (PCSrc=4 trap vector).
module control_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] inst_op,
  input  logic       overflow,
  input  logic       comp_zero,
  output logic       MemWrite,
  output logic [1:0] MemSrc,
  output logic [2:0] MemDst,
  output logic [2:0] PCSrc,
  output logic [2:0] SPSrc,
  output logic       PCWrite,
  output logic       SPWrite,
  output logic       InstWrite,
  output logic       mary_write,
  output logic       shelley_write,
  output logic       comp_write,
  output logic       ra_write,
  output logic [1:0] mary_src,
  output logic [1:0] shelley_src,
  output logic       ra_src,
  output logic       SrcA,
  output logic [1:0] SrcB,
  output logic [3:0] AluOp,
  output logic       halted,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'h01;
  localparam logic [4:0] OP_ADDI = 5'h02;
  localparam logic [4:0] OP_LW   = 5'h08;
  localparam logic [4:0] OP_SW   = 5'h09;
  localparam logic [4:0] OP_JAL  = 5'h10;
  localparam logic [4:0] OP_JR   = 5'h11;
  localparam logic [4:0] OP_BEQ  = 5'h12;
  localparam logic [4:0] OP_PUSH = 5'h18;
  localparam logic [4:0] OP_POP  = 5'h19;
  localparam logic [4:0] OP_HALT = 5'h1F;

  state_t     state_q, state_d;
  logic [4:0] op_q;

`ifndef CONTROL_OVERFLOW_TRAP_EN
  logic unused_overflow;
  assign unused_overflow = overflow;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= 5'h00;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= inst_op;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (op_q)
`ifdef CONTROL_OVERFLOW_TRAP_EN
          OP_ADD, OP_ADDI: state_d = overflow ? S_TRAP : S_WB;
`else
          OP_ADD, OP_ADDI: state_d = S_WB;
`endif
          OP_LW, OP_SW, OP_PUSH, OP_POP: state_d = S_MEM;
          OP_HALT: state_d = S_HALT;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM:  state_d = (op_q == OP_LW || op_q == OP_POP) ? S_WB : S_FETCH;
      S_WB:   state_d = S_FETCH;
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    MemWrite      = 1'b0;
    MemSrc        = 2'd0;
    MemDst        = 3'd0;
    PCSrc         = 3'd0;
    SPSrc         = 3'd0;
    PCWrite       = 1'b0;
    SPWrite       = 1'b0;
    InstWrite     = 1'b0;
    mary_write    = 1'b0;
    shelley_write = 1'b0;
    comp_write    = 1'b0;
    ra_write      = 1'b0;
    mary_src      = 2'd0;
    shelley_src   = 2'd0;
    ra_src        = 1'b0;
    SrcA          = 1'b0;
    SrcB          = 2'd0;
    AluOp         = 4'd0;
    case (state_q)
      S_FETCH: begin
        InstWrite = 1'b1;
        PCWrite   = 1'b1;
      end
      S_EXEC: begin
        case (op_q)
          OP_ADDI: SrcB = 2'd1;
          OP_JAL: begin
            ra_write = 1'b1;
            PCWrite  = 1'b1;
            PCSrc    = 3'd3;
          end
          OP_JR: begin
            PCWrite = 1'b1;
            PCSrc   = 3'd2;
          end
          // comp_zero is only looked at here, so it cannot disturb other states
          OP_BEQ: begin
            PCWrite = comp_zero;
            PCSrc   = comp_zero ? 3'd1 : 3'd0;
          end
          OP_PUSH: SPWrite = 1'b1;
          default: ;
        endcase
      end
      S_MEM: begin
        case (op_q)
          OP_LW: MemSrc = 2'd1;
          OP_SW: begin
            MemWrite = 1'b1;
            MemSrc   = 2'd1;
          end
          OP_PUSH: begin
            MemWrite = 1'b1;
            MemSrc   = 2'd2;
          end
          OP_POP: MemSrc = 2'd2;
          default: ;
        endcase
      end
      S_WB: begin
        mary_write = 1'b1;
        if (op_q == OP_LW || op_q == OP_POP) mary_src = 2'd1;
        if (op_q == OP_POP) begin
          SPWrite = 1'b1;
          SPSrc   = 3'd1;
        end
      end
`ifdef CONTROL_OVERFLOW_TRAP_EN
      S_TRAP: begin
        PCWrite = 1'b1;
        PCSrc   = 3'd4;
      end
`endif
      default: ;
    endcase
    // Reset wins over the current state: nothing may be written on the reset edge
    if (reset) begin
      MemWrite   = 1'b0;
      PCWrite    = 1'b0;
      SPWrite    = 1'b0;
      InstWrite  = 1'b0;
      mary_write = 1'b0;
      ra_write   = 1'b0;
    end
  end

  assign halted = (state_q == S_HALT);
  assign state  = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
module tb_control_sequencer;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] inst_op = 5'h00;
  logic       overflow = 1'b0;
  logic       comp_zero = 1'b0;
  logic       MemWrite, PCWrite, SPWrite, InstWrite;
  logic       mary_write, shelley_write, comp_write, ra_write, ra_src, SrcA, halted;
  logic [1:0] MemSrc, mary_src, shelley_src, SrcB;
  logic [2:0] MemDst, PCSrc, SPSrc, state;
  logic [3:0] AluOp;
  int checks = 0;
  int fails = 0;

  control_sequencer dut (
    .clock(clock), .reset(reset), .inst_op(inst_op), .overflow(overflow), .comp_zero(comp_zero),
    .MemWrite(MemWrite), .MemSrc(MemSrc), .MemDst(MemDst), .PCSrc(PCSrc), .SPSrc(SPSrc),
    .PCWrite(PCWrite), .SPWrite(SPWrite), .InstWrite(InstWrite),
    .mary_write(mary_write), .shelley_write(shelley_write), .comp_write(comp_write), .ra_write(ra_write),
    .mary_src(mary_src), .shelley_src(shelley_src), .ra_src(ra_src),
    .SrcA(SrcA), .SrcB(SrcB), .AluOp(AluOp), .halted(halted), .state(state)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [6:0] enables();
    return {MemWrite, PCWrite, SPWrite, InstWrite, mary_write, ra_write, shelley_write | comp_write};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++; if (state !== 3'd0) begin fails++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (enables() !== 7'b0) begin fails++; $display("FAIL reset_gated_enables got=%b exp=0", enables()); end
    reset = 1'b0;
    #1;
    checks++; if ({InstWrite, PCWrite, PCSrc, MemSrc} !== {1'b1, 1'b1, 3'd0, 2'd0}) begin
      fails++; $display("FAIL reset_fetch_out got=%b exp=%b", {InstWrite, PCWrite, PCSrc, MemSrc}, 7'b1100000); end
    checks++; if ({halted, state} !== 4'b0) begin fails++; $display("FAIL reset_halted_state got=%b exp=0000", {halted, state}); end
  endtask

  task automatic test_add(input logic [4:0] op, input logic [1:0] exp_srcb);
    inst_op = op;
    step();
    checks++; if (state !== 3'd1 || enables() !== 7'b0) begin fails++; $display("FAIL add_decode state=%0d en=%b exp=1/0", state, enables()); end
    step();
    checks++; if ({state, AluOp, SrcA, SrcB, mary_write} !== {3'd2, 4'd0, 1'b0, exp_srcb, 1'b0}) begin
      fails++; $display("FAIL add_exec op=%h got=%b exp=%b", op, {state, AluOp, SrcA, SrcB, mary_write}, {3'd2, 4'd0, 1'b0, exp_srcb, 1'b0}); end
    step();
    checks++; if ({state, mary_write, mary_src} !== {3'd4, 1'b1, 2'd0}) begin
      fails++; $display("FAIL add_wb got=%b exp=%b", {state, mary_write, mary_src}, {3'd4, 1'b1, 2'd0}); end
    step();
    checks++; if (state !== 3'd0) begin fails++; $display("FAIL add_return state=%0d exp=0", state); end
  endtask

  task automatic test_beq(input logic cz);
    inst_op = 5'h12;
    comp_zero = ~cz;
    step();
    comp_zero = cz;
    step();
    checks++; if ({state, PCWrite, PCSrc, SPWrite} !== {3'd2, cz, (cz ? 3'd1 : 3'd0), 1'b0}) begin
      fails++; $display("FAIL beq_exec cz=%0b got=%b exp=%b", cz, {state, PCWrite, PCSrc, SPWrite}, {3'd2, cz, (cz ? 3'd1 : 3'd0), 1'b0}); end
    comp_zero = ~cz;
    #1;
    checks++; if (PCWrite !== ~cz) begin fails++; $display("FAIL beq_exec_follow got=%b exp=%b", PCWrite, ~cz); end
    step();
    checks++; if (state !== 3'd0) begin fails++; $display("FAIL beq_return state=%0d exp=0", state); end
    comp_zero = 1'b0;
  endtask

  task automatic test_jump(input logic [4:0] op, input logic [2:0] exp_pcsrc, input logic exp_ra);
    inst_op = op;
    step(); step();
    checks++; if ({PCWrite, PCSrc, ra_write, ra_src, SPWrite} !== {1'b1, exp_pcsrc, exp_ra, 1'b0, 1'b0}) begin
      fails++; $display("FAIL jump_exec op=%h got=%b exp=%b", op, {PCWrite, PCSrc, ra_write, ra_src, SPWrite}, {1'b1, exp_pcsrc, exp_ra, 1'b0, 1'b0}); end
    step();
    checks++; if (state !== 3'd0) begin fails++; $display("FAIL jump_return state=%0d exp=0", state); end
  endtask

  task automatic test_lw();
    inst_op = 5'h08;
    step(); step();
    checks++; if ({state, enables()} !== {3'd2, 7'b0}) begin fails++; $display("FAIL lw_exec got=%b exp=%b", {state, enables()}, {3'd2, 7'b0}); end
    step();
    checks++; if ({state, MemSrc, MemWrite} !== {3'd3, 2'd1, 1'b0}) begin fails++; $display("FAIL lw_mem got=%b exp=%b", {state, MemSrc, MemWrite}, {3'd3, 2'd1, 1'b0}); end
    step();
    checks++; if ({state, mary_write, mary_src, SPWrite} !== {3'd4, 1'b1, 2'd1, 1'b0}) begin
      fails++; $display("FAIL lw_wb got=%b exp=%b", {state, mary_write, mary_src, SPWrite}, {3'd4, 1'b1, 2'd1, 1'b0}); end
    step();
    checks++; if (state !== 3'd0) begin fails++; $display("FAIL lw_return state=%0d exp=0", state); end
  endtask

  task automatic test_push_pop();
    inst_op = 5'h18;
    step(); step();
    checks++; if ({SPWrite, SPSrc, PCWrite} !== {1'b1, 3'd0, 1'b0}) begin fails++; $display("FAIL push_exec got=%b exp=%b", {SPWrite, SPSrc, PCWrite}, 5'b10000); end
    step();
    checks++; if ({state, MemWrite, MemSrc, MemDst, SPWrite} !== {3'd3, 1'b1, 2'd2, 3'd0, 1'b0}) begin
      fails++; $display("FAIL push_mem got=%b exp=%b", {state, MemWrite, MemSrc, MemDst, SPWrite}, {3'd3, 1'b1, 2'd2, 3'd0, 1'b0}); end
    step();
    checks++; if (state !== 3'd0) begin fails++; $display("FAIL push_return state=%0d exp=0", state); end
    inst_op = 5'h19;
    step(); step(); step();
    checks++; if ({state, MemWrite, MemSrc} !== {3'd3, 1'b0, 2'd2}) begin fails++; $display("FAIL pop_mem got=%b exp=%b", {state, MemWrite, MemSrc}, {3'd3, 1'b0, 2'd2}); end
    step();
    checks++; if ({state, mary_write, mary_src, SPWrite, SPSrc, PCWrite} !== {3'd4, 1'b1, 2'd1, 1'b1, 3'd1, 1'b0}) begin
      fails++; $display("FAIL pop_wb got=%b exp=%b", {state, mary_write, mary_src, SPWrite, SPSrc, PCWrite}, {3'd4, 1'b1, 2'd1, 1'b1, 3'd1, 1'b0}); end
    step();
    checks++; if (state !== 3'd0) begin fails++; $display("FAIL pop_return state=%0d exp=0", state); end
  endtask

  task automatic test_nop();
    inst_op = 5'h05;
    step(); step();
    checks++; if ({state, enables()} !== {3'd2, 7'b0}) begin fails++; $display("FAIL nop_exec got=%b exp=%b", {state, enables()}, {3'd2, 7'b0}); end
    step();
    checks++; if (state !== 3'd0) begin fails++; $display("FAIL nop_return state=%0d exp=0", state); end
  endtask

  task automatic test_overflow();
    inst_op = 5'h01;
    step(); step();
    overflow = 1'b1;
    step();
    overflow = 1'b0;
`ifdef CONTROL_OVERFLOW_TRAP_EN
    checks++; if ({state, PCWrite, PCSrc, mary_write} !== {3'd6, 1'b1, 3'd4, 1'b0}) begin
      fails++; $display("FAIL ovf_trap got=%b exp=%b", {state, PCWrite, PCSrc, mary_write}, {3'd6, 1'b1, 3'd4, 1'b0}); end
`else
    checks++; if ({state, mary_write, PCWrite} !== {3'd4, 1'b1, 1'b0}) begin
      fails++; $display("FAIL ovf_ignored got=%b exp=%b", {state, mary_write, PCWrite}, {3'd4, 1'b1, 1'b0}); end
`endif
    step();
    checks++; if (state !== 3'd0) begin fails++; $display("FAIL ovf_return state=%0d exp=0", state); end
  endtask

  task automatic test_sw_reset();
    inst_op = 5'h09;
    step(); step(); step();
    checks++; if ({state, MemWrite, MemSrc, MemDst} !== {3'd3, 1'b1, 2'd1, 3'd0}) begin
      fails++; $display("FAIL sw_mem got=%b exp=%b", {state, MemWrite, MemSrc, MemDst}, {3'd3, 1'b1, 2'd1, 3'd0}); end
    reset = 1'b1;
    #1;
    checks++; if (enables() !== 7'b0) begin fails++; $display("FAIL sw_reset_gate got=%b exp=0", enables()); end
    step();
    reset = 1'b0;
    #1;
    checks++; if ({state, InstWrite} !== {3'd0, 1'b1}) begin fails++; $display("FAIL sw_reset_fetch got=%b exp=0001", {state, InstWrite}); end
  endtask

  task automatic test_halt();
    int bad = 0;
    inst_op = 5'h1F;
    step(); step(); step();
    inst_op = 5'h01;
    for (int i = 0; i < 20; i++) begin
      comp_zero = i[0];
      overflow = i[1];
      if ({state, halted, enables()} !== {3'd5, 1'b1, 7'b0}) bad++;
      step();
    end
    comp_zero = 1'b0;
    overflow = 1'b0;
    checks++; if (bad != 0) begin fails++; $display("FAIL halt_hold bad_cycles=%0d exp=0", bad); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++; if ({state, halted, InstWrite} !== {3'd0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL halt_reset got=%b exp=%b", {state, halted, InstWrite}, 5'b00001); end
  endtask

  initial begin
    test_reset();
    test_add(5'h01, 2'd0);
    test_add(5'h02, 2'd1);
    test_beq(1'b1);
    test_beq(1'b0);
    test_jump(5'h10, 3'd3, 1'b1);
    test_jump(5'h11, 3'd2, 1'b0);
    test_lw();
    test_push_pop();
    test_nop();
    test_overflow();
    test_sw_reset();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
